// File: rtl/m3_motor_cmd_sequencer_if.sv
// Operator panel / calc-block pin bundle for the motor command sequencer.
// slave is the sequencer's view, master is the panel+calc side.
interface m3_motor_cmd_sequencer_if;
  logic       tick100hzI;
  logic       btnStartI;
  logic       btnStopI;
  logic       btnRevI;
  logic       btnSpdUpI;
  logic       btnSpdDnI;
  logic       btnPwrUpI;
  logic       btnPwrDnI;
  logic       forceStopI;
  logic       atMinSpeedI;
  logic       m3startO;
  logic       m3forceStopO;
  logic       m3invRotateO;
  logic       m3speedINCo;
  logic       m3speedDECo;
  logic       m3powerINCo;
  logic       m3powerDECo;
  logic [2:0] stateO;

  modport slave (
    input  tick100hzI, btnStartI, btnStopI, btnRevI, btnSpdUpI, btnSpdDnI,
           btnPwrUpI, btnPwrDnI, forceStopI, atMinSpeedI,
    output m3startO, m3forceStopO, m3invRotateO, m3speedINCo, m3speedDECo,
           m3powerINCo, m3powerDECo, stateO
  );

  modport master (
    output tick100hzI, btnStartI, btnStopI, btnRevI, btnSpdUpI, btnSpdDnI,
           btnPwrUpI, btnPwrDnI, forceStopI, atMinSpeedI,
    input  m3startO, m3forceStopO, m3invRotateO, m3speedINCo, m3speedDECo,
           m3powerINCo, m3powerDECo, stateO
  );
endinterface

// File: rtl/m3_motor_cmd_sequencer.sv
// Operator-command sequencer in front of m3_powerAndSpeedCalc.
// Debounces panel buttons on the 100 Hz tick, arbitrates commands and
// sequences direction reversal as ramp-down / dwell / flip / ramp-up.
module m3_motor_cmd_sequencer #(
  parameter int DEB_TICKS    = 3,
  parameter int RAMP_TIMEOUT = 1000,
  parameter int REV_DWELL    = 50,
  parameter int BRAKE_TICKS  = 20,
  parameter int CNT_W        = 16
) (
  input  logic                     clkI,
  input  logic                     nRstI,
  m3_motor_cmd_sequencer_if.slave  bus
);

  localparam int NUM_BTN  = 7;
  localparam int B_START  = 0;
  localparam int B_STOP   = 1;
  localparam int B_REV    = 2;
  localparam int B_SPD_UP = 3;
  localparam int B_SPD_DN = 4;
  localparam int B_PWR_UP = 5;
  localparam int B_PWR_DN = 6;

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] DEB_C   = CNT_W'(DEB_TICKS);
  localparam logic [CNT_W-1:0] RTO_C   = CNT_W'(RAMP_TIMEOUT);
  localparam logic [CNT_W-1:0] DWELL_C = CNT_W'(REV_DWELL);
  localparam logic [CNT_W-1:0] BRAKE_C = CNT_W'(BRAKE_TICKS);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN      = 3'd1,
    S_RAMP_DN  = 3'd2,
    S_REV_STOP = 3'd3,
    S_RAMP_UP  = 3'd4,
    S_BRAKE    = 3'd5
  } state_e;

  typedef struct packed {
    logic start;
    logic force_stop;
    logic spd_inc;
    logic spd_dec;
    logic pwr_inc;
    logic pwr_dec;
  } out_t;

  // ---------------------------------------------------------------------
  // Tick edge detect and forceStop synchroniser
  // ---------------------------------------------------------------------
  logic tick_q, fs_s1_q, fs_s2_q;
  logic tick_evt;

  assign tick_evt = bus.tick100hzI & ~tick_q;

  // Tick history for edge detection; two-flop sync on the emergency stop level
  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      tick_q  <= 1'b0;
      fs_s1_q <= 1'b0;
      fs_s2_q <= 1'b0;
    end else begin
      tick_q  <= bus.tick100hzI;
      fs_s1_q <= bus.forceStopI;
      fs_s2_q <= fs_s1_q;
    end
  end

  // ---------------------------------------------------------------------
  // Button debounce: run-length of equal tick samples per button
  // ---------------------------------------------------------------------
  logic [NUM_BTN-1:0]            btn_raw;
  logic [NUM_BTN-1:0]            deb_last_q, deb_last_d;
  logic [NUM_BTN-1:0]            stable_q, stable_d;
  logic [NUM_BTN-1:0][CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [NUM_BTN-1:0]            press;

  assign btn_raw = {bus.btnPwrDnI, bus.btnPwrUpI, bus.btnSpdDnI, bus.btnSpdUpI,
                    bus.btnRevI, bus.btnStopI, bus.btnStartI};

  // Press is taken from the next stable level so FSM reacts on the tick clk itself
  assign press = stable_d & ~stable_q;

  // On each tick extend or restart the run of equal samples; accept level once long enough
  always_comb begin
    deb_last_d = deb_last_q;
    deb_cnt_d  = deb_cnt_q;
    stable_d   = stable_q;
    if (tick_evt) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (btn_raw[i] == deb_last_q[i]) begin
          if (deb_cnt_q[i] < DEB_C) deb_cnt_d[i] = deb_cnt_q[i] + ONE;
        end else begin
          deb_cnt_d[i] = ONE;
        end
        deb_last_d[i] = btn_raw[i];
        if (deb_cnt_d[i] >= DEB_C) stable_d[i] = btn_raw[i];
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      deb_last_q <= '0;
      deb_cnt_q  <= '0;
      stable_q   <= '0;
    end else begin
      deb_last_q <= deb_last_d;
      deb_cnt_q  <= deb_cnt_d;
      stable_q   <= stable_d;
    end
  end

  // ---------------------------------------------------------------------
  // Command FSM
  // ---------------------------------------------------------------------
  state_e           state_q, state_d;
  logic             tgt_rev_q, tgt_rev_d;
  logic             inv_q, inv_d;
  logic [CNT_W-1:0] ramp_q, ramp_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] brake_q, brake_d;

  // Next state and counters; a state exit suppresses that clk's count update
  always_comb begin
    state_d   = state_q;
    tgt_rev_d = tgt_rev_q;
    inv_d     = inv_q;
    ramp_d    = ramp_q;
    dwell_d   = dwell_q;
    brake_d   = brake_q;
    if (fs_s2_q && state_q != S_BRAKE) begin
      state_d = S_BRAKE;
      brake_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (press[B_START] && !press[B_STOP]) state_d = S_RUN;
        end
        S_RUN: begin
          if (press[B_STOP]) begin
            state_d   = S_RAMP_DN;
            tgt_rev_d = 1'b0;
            ramp_d    = '0;
          end else if (press[B_REV]) begin
            state_d   = S_RAMP_DN;
            tgt_rev_d = 1'b1;
            ramp_d    = '0;
          end
        end
        S_RAMP_DN: begin
          if (bus.atMinSpeedI || ramp_q == RTO_C) begin
            // rampCnt is kept: RAMP_UP counts it back down to restore speed
            if (tgt_rev_q && !press[B_STOP]) begin
              state_d = S_REV_STOP;
              dwell_d = '0;
              inv_d   = ~inv_q;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            if (press[B_STOP]) tgt_rev_d = 1'b0;
            if (tick_evt && ramp_q != CNT_MAX) ramp_d = ramp_q + ONE;
          end
        end
        S_REV_STOP: begin
          if (press[B_STOP]) begin
            state_d = S_IDLE;
          end else if (dwell_q == DWELL_C) begin
            state_d = S_RAMP_UP;
          end else if (tick_evt && dwell_q != CNT_MAX) begin
            dwell_d = dwell_q + ONE;
          end
        end
        S_RAMP_UP: begin
          if (press[B_STOP]) begin
            state_d   = S_RAMP_DN;
            tgt_rev_d = 1'b0;
            ramp_d    = '0;
          end else if (ramp_q == '0) begin
            state_d = S_RUN;
          end else if (tick_evt) begin
            ramp_d = ramp_q - ONE;
          end
        end
        S_BRAKE: begin
          if (!fs_s2_q && brake_q >= BRAKE_C) begin
            state_d = S_IDLE;
          end else if (tick_evt && brake_q != CNT_MAX) begin
            brake_d = brake_q + ONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM state, target, direction and counter registers
  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      state_q   <= S_IDLE;
      tgt_rev_q <= 1'b0;
      inv_q     <= 1'b0;
      ramp_q    <= '0;
      dwell_q   <= '0;
      brake_q   <= '0;
    end else begin
      state_q   <= state_d;
      tgt_rev_q <= tgt_rev_d;
      inv_q     <= inv_d;
      ramp_q    <= ramp_d;
      dwell_q   <= dwell_d;
      brake_q   <= brake_d;
    end
  end

  // ---------------------------------------------------------------------
  // Registered control pins
  // ---------------------------------------------------------------------
  out_t out_q, out_d;

  // Pin levels decoded from the current state and stable button levels
  always_comb begin
    out_d = '0;
    case (state_q)
      S_RUN: begin
        out_d.start   = 1'b1;
        out_d.spd_inc = stable_q[B_SPD_UP] & ~stable_q[B_SPD_DN];
        out_d.spd_dec = stable_q[B_SPD_DN] & ~stable_q[B_SPD_UP];
        out_d.pwr_inc = stable_q[B_PWR_UP] & ~stable_q[B_PWR_DN];
        out_d.pwr_dec = stable_q[B_PWR_DN] & ~stable_q[B_PWR_UP];
      end
      S_RAMP_DN: begin
        out_d.start   = 1'b1;
        out_d.spd_dec = 1'b1;
      end
      S_RAMP_UP: begin
        out_d.start   = 1'b1;
        out_d.spd_inc = 1'b1;
      end
      S_BRAKE:   out_d.force_stop = 1'b1;
      default:   ;
    endcase
  end

  // Output register
  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) out_q <= '0;
    else        out_q <= out_d;
  end

  assign bus.m3startO     = out_q.start;
  assign bus.m3forceStopO = out_q.force_stop;
  assign bus.m3speedINCo  = out_q.spd_inc;
  assign bus.m3speedDECo  = out_q.spd_dec;
  assign bus.m3powerINCo  = out_q.pwr_inc;
  assign bus.m3powerDECo  = out_q.pwr_dec;
  assign bus.m3invRotateO = inv_q;
  assign bus.stateO       = state_q;

endmodule

// File: tb/tb_m3_motor_cmd_sequencer.sv
// Bench for m3_motor_cmd_sequencer. A tick-granular reference model predicts
// state transitions and settled pin levels; a monitor process compares them
// against the DUT as stateO changes and as snapshots fall due.
module tb_m3_motor_cmd_sequencer;
  localparam int DEB = 3, RTO = 1000, DWELL = 50, BRK = 20;
  localparam int S_IDLE = 0, S_RUN = 1, S_RDN = 2, S_RSTOP = 3, S_RUP = 4, S_BRAKE = 5;
  localparam logic [6:0] B_START = 7'h01, B_STOP = 7'h02, B_REV = 7'h04,
                         B_UP = 7'h08, B_DN = 7'h10, B_PU = 7'h20, B_PD = 7'h40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] btn = '0;
  logic tick = 1'b0, fs_lvl = 1'b0, atmin_lvl = 1'b0;
  int cyc = 0;
  int vec_cnt = 0, miss_cnt = 0;

  m3_motor_cmd_sequencer_if bus();
  assign bus.tick100hzI  = tick;
  assign bus.btnStartI   = btn[0];
  assign bus.btnStopI    = btn[1];
  assign bus.btnRevI     = btn[2];
  assign bus.btnSpdUpI   = btn[3];
  assign bus.btnSpdDnI   = btn[4];
  assign bus.btnPwrUpI   = btn[5];
  assign bus.btnPwrDnI   = btn[6];
  assign bus.forceStopI  = fs_lvl;
  assign bus.atMinSpeedI = atmin_lvl;

  m3_motor_cmd_sequencer #(.DEB_TICKS(DEB), .RAMP_TIMEOUT(RTO), .REV_DWELL(DWELL),
                           .BRAKE_TICKS(BRK), .CNT_W(16))
    dut (.clkI(clk), .nRstI(rst_n), .bus(bus));

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct { int due; logic [6:0] vec; int st; } snap_t;
  int    exp_state_q[$];
  snap_t exp_out_q[$];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // ---------------- reference model ----------------
  int         m_state = S_IDLE, m_ramp = 0, m_dwell = 0, m_brake = 0;
  bit         m_tgt_rev = 0, m_inv = 0;
  logic [6:0] m_stable = '0;
  logic [6:0] m_hist[$];

  function automatic void m_goto(int ns);
    if (ns == m_state) return;
    m_state = ns;
    exp_state_q.push_back(ns);
    case (ns)
      S_RDN:   m_ramp = 0;
      S_RSTOP: begin m_dwell = 0; m_inv = ~m_inv; end
      S_BRAKE: m_brake = 0;
      default: ;
    endcase
  endfunction

  function automatic void m_reset();
    if (m_state != S_IDLE) exp_state_q.push_back(S_IDLE);
    m_state = S_IDLE; m_ramp = 0; m_dwell = 0; m_brake = 0;
    m_tgt_rev = 0; m_inv = 0; m_stable = '0;
    m_hist.delete();
  endfunction

  // Level-driven exits that do not need a tick
  function automatic void m_settle();
    int prev;
    for (int k = 0; k < 8; k++) begin
      prev = m_state;
      if (fs_lvl && m_state != S_BRAKE) m_goto(S_BRAKE);
      else case (m_state)
        S_BRAKE: if (!fs_lvl && m_brake >= BRK) m_goto(S_IDLE);
        S_RDN:   if (atmin_lvl || m_ramp == RTO) m_goto(m_tgt_rev ? S_RSTOP : S_IDLE);
        S_RSTOP: if (m_dwell == DWELL) m_goto(S_RUP);
        S_RUP:   if (m_ramp == 0) m_goto(S_RUN);
        default: ;
      endcase
      if (prev == m_state) break;
    end
  endfunction

  // One 100 Hz tick: debounce from the last DEB samples, then commands and counts
  function automatic void m_tick(logic [6:0] b);
    logic [6:0] old, pr;
    logic v;
    bit same;
    old = m_stable;
    m_hist.push_back(b);
    if (m_hist.size() > DEB) void'(m_hist.pop_front());
    if (m_hist.size() == DEB) begin
      for (int i = 0; i < 7; i++) begin
        v = m_hist[0][i];
        same = 1;
        for (int j = 1; j < DEB; j++) if (m_hist[j][i] != v) same = 0;
        if (same) m_stable[i] = v;
      end
    end
    pr = m_stable & ~old;
    case (m_state)
      S_IDLE:  if (pr[0] && !pr[1]) m_goto(S_RUN);
      S_RUN: begin
        if (pr[1])      begin m_tgt_rev = 0; m_goto(S_RDN); end
        else if (pr[2]) begin m_tgt_rev = 1; m_goto(S_RDN); end
      end
      S_RDN: begin
        if (pr[1]) m_tgt_rev = 0;
        m_ramp++;
      end
      S_RSTOP: if (pr[1]) m_goto(S_IDLE); else m_dwell++;
      S_RUP: begin
        if (pr[1]) begin m_tgt_rev = 0; m_goto(S_RDN); end
        else if (m_ramp > 0) m_ramp--;
      end
      S_BRAKE: m_brake++;
      default: ;
    endcase
  endfunction

  // {forceStop, start, invRotate, spdInc, spdDec, pwrInc, pwrDec}
  function automatic logic [6:0] m_outs();
    logic [6:0] v;
    v = '0;
    v[4] = m_inv;
    case (m_state)
      S_RUN: begin
        v[5] = 1'b1;
        v[3] = m_stable[3] & ~m_stable[4];
        v[2] = m_stable[4] & ~m_stable[3];
        v[1] = m_stable[5] & ~m_stable[6];
        v[0] = m_stable[6] & ~m_stable[5];
      end
      S_RDN:   begin v[5] = 1'b1; v[2] = 1'b1; end
      S_RUP:   begin v[5] = 1'b1; v[3] = 1'b1; end
      S_BRAKE: v[6] = 1'b1;
      default: ;
    endcase
    return v;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic [2:0] last_st;
    snap_t s;
    last_st = 3'd0;
    forever begin
      @(negedge clk);
      if (bus.stateO !== last_st) begin
        if (exp_state_q.size() == 0) chk("unexpected_state_change", 32'(bus.stateO), 32'(last_st));
        else chk("state_sequence", 32'(bus.stateO), 32'(exp_state_q.pop_front()));
        last_st = bus.stateO;
      end
      if (exp_out_q.size() > 0 && exp_out_q[0].due <= cyc) begin
        s = exp_out_q.pop_front();
        chk("pins", 32'({bus.m3forceStopO, bus.m3startO, bus.m3invRotateO, bus.m3speedINCo,
                         bus.m3speedDECo, bus.m3powerINCo, bus.m3powerDECo}), 32'(s.vec));
        chk("state_settled", 32'(bus.stateO), 32'(s.st));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [6:0] b, input bit fs, input bit am);
    @(posedge clk); #2;
    btn = b; fs_lvl = fs; atmin_lvl = am;
    m_settle();
    repeat (5) @(posedge clk);
    #2;
    tick = 1'b1;
    m_tick(b);
    m_settle();
    @(posedge clk); #2;
    tick = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    exp_out_q.push_back('{cyc, m_outs(), m_state});
  endtask

  task automatic hold(input logic [6:0] b, input int n, input bit fs, input bit am);
    for (int i = 0; i < n; i++) step(b, fs, am);
  endtask

  task automatic reset_pulse();
    @(posedge clk); #2;
    btn = '0; fs_lvl = 1'b0; atmin_lvl = 1'b0; tick = 1'b0;
    rst_n = 1'b0;
    m_reset();
    exp_out_q.push_back('{cyc, 7'd0, S_IDLE});
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [6:0] rb;
    bit rfs, ram, nfs;
    // reset state
    repeat (3) @(posedge clk);
    #2;
    exp_out_q.push_back('{cyc, 7'd0, S_IDLE});
    @(posedge clk); #2;
    rst_n = 1'b1;

    // start glitch of 2 ticks ignored, 3 ticks accepted
    hold(B_START, 2, 0, 0);
    hold(7'd0, 4, 0, 0);
    hold(B_START, 3, 0, 0);
    hold(7'd0, 3, 0, 0);

    // speed/power buttons in RUN, both held cancels
    hold(B_UP | B_DN, 4, 0, 0);
    hold(B_UP, 4, 0, 0);
    hold(7'd0, 3, 0, 0);
    hold(B_PU, 4, 0, 0);
    hold(B_PU | B_PD, 4, 0, 0);
    hold(B_PD, 4, 0, 0);
    hold(7'd0, 3, 0, 0);

    // reversal: min speed after ~40 ticks, dwell, ramp back up to RUN
    hold(B_REV, 3, 0, 0);
    hold(7'd0, 37, 0, 0);
    hold(7'd0, 2, 0, 1);
    hold(7'd0, 100, 0, 0);

    // reset mid-RUN with inverted direction
    hold(B_UP, 4, 0, 0);
    reset_pulse();
    hold(7'd0, 3, 0, 0);

    // ramp-down timeout with no min-speed indication
    hold(B_START, 3, 0, 0);
    hold(7'd0, 3, 0, 0);
    hold(B_STOP, 3, 0, 0);
    hold(7'd0, 1003, 0, 0);

    // stop press during reverse ramp goes to IDLE, direction unchanged
    hold(B_START, 3, 0, 0);
    hold(7'd0, 3, 0, 0);
    hold(B_REV, 3, 0, 0);
    hold(7'd0, 10, 0, 0);
    hold(B_STOP, 3, 0, 0);
    hold(7'd0, 3, 0, 0);
    hold(7'd0, 2, 0, 1);
    hold(7'd0, 2, 0, 0);

    // forceStop pulse in RAMP_UP, then a long forceStop
    hold(B_START, 3, 0, 0);
    hold(7'd0, 3, 0, 0);
    hold(B_REV, 3, 0, 0);
    hold(7'd0, 30, 0, 0);
    hold(7'd0, 1, 0, 1);
    hold(7'd0, 52, 0, 0);
    hold(7'd0, 5, 1, 0);
    hold(7'd0, 25, 0, 0);
    hold(7'd0, 100, 1, 0);
    hold(7'd0, 3, 0, 0);

    // randomized operation
    rb = '0; rfs = 0; ram = 0;
    for (int n = 0; n < 1200; n++) begin
      nfs = rfs;
      if (rfs) begin
        if ($urandom_range(0, 7) == 0) nfs = 0;
      end else if ($urandom_range(0, 79) == 0) nfs = 1;
      if (nfs == rfs && $urandom_range(0, 9) == 0) ram = ~ram;
      rfs = nfs;
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0:       rb = '0;
          1, 2:    rb = 7'(32'd1 << $urandom_range(0, 6));
          default: rb = 7'($urandom) & 7'($urandom);
        endcase
      end
      step(rb, rfs, ram);
    end

    repeat (4) @(posedge clk);
    #2;
    chk("scoreboard_drain", 32'(exp_out_q.size() + exp_state_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: bench did not finish, %0d vectors, %0d miscompares", vec_cnt, miss_cnt);
    $fatal(1, "watchdog");
  end

endmodule
